alu_req_arbiter: RTL
====================

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, meaning ALU combinational settle cycles between operand launch and capture (legal 1..7).
REQ-002 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester 0/1 has a command.
REQ-006 req0_ready / req1_ready  output  1  command accepted when valid&ready at a rising edge.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  8  operands.
REQ-008 req0_op, req1_op  input  11  one-hot op code: bit0 add, bit1 sub, bit2 mult, bit3 div.
REQ-009 rsp_valid  output  1  result held valid until taken.
REQ-010 rsp_ready  input  1  consumer takes result when rsp_valid&rsp_ready at a rising edge.
REQ-011 rsp_id  output  1  requester that issued the result.
REQ-012 rsp_out  output  8  ALU result; rsp_rem  output  3  division remainder.
REQ-013 rsp_err  output  1  illegal op code or divide by zero.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, RESP; only IDLE SHALL assert a ready.
REQ-015 In IDLE, at most one of req0_ready/req1_ready SHALL be high, driven combinationally from valids and the round-robin pointer.
REQ-016 Arbitration: single valid wins; both valid -> requester not granted last wins; pointer updates only on accept; reset pointer favours requester 0.
REQ-017 On accept, a, b, op and requester id SHALL be latched and state SHALL go to ISSUE.
REQ-018 ISSUE SHALL hold the latched operands on the ALU for exactly SETTLE_CYCLES cycles, then capture out/rem into rsp registers and enter RESP.
REQ-019 Latency with SETTLE_CYCLES=1: rsp_valid rises at the second rising edge after the accept edge.
REQ-020 RESP SHALL hold rsp_valid=1 and all rsp_* stable until rsp_ready=1; then return to IDLE; no accept in the same cycle.
REQ-021 Op codes other than the four one-hot values SHALL yield rsp_out=0, rsp_rem=0, rsp_err=1, with normal latency.
REQ-022 Div with b=0 SHALL yield rsp_out=0, rsp_rem=0, rsp_err=1.
REQ-023 Arithmetic is 8-bit truncating; sub returns |a-b|; rem is the low 3 bits of a%b.
REQ-024 Requester valids changing in ISSUE/RESP SHALL have no effect; a dropped valid in IDLE is not a commitment.

Reset
REQ-025 Reset SHALL force IDLE, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_rem=0, rsp_err=0, pointer=requester 0, latched operands 0.
REQ-026 Reset asserted mid-ISSUE or mid-RESP SHALL abort the operation; no response SHALL be produced after release.

Structure
REQ-027 Package alu_ctrl_pkg SHALL hold the op-code constants (OP_ADD, OP_SUB, OP_MULT, OP_DIV) and the FSM state enum.
REQ-028 One sub-module, eight_bit_alu, SHALL be instantiated, fed only from latched registers.

Verification
REQ-029 req0 a=7 b=3 op=ADD, rsp_ready=1 -> rsp_out=10, rem=0, err=0, id=0, rsp_valid two edges after accept.
REQ-030 req1 a=3 b=7 op=SUB -> rsp_out=4, id=1; a=16 b=16 op=MULT -> rsp_out=0, err=0.
REQ-031 req0 a=17 b=5 op=DIV -> out=3, rem=2; a=9 b=0 op=DIV -> out=0, rem=0, err=1.
REQ-032 Both valid continuously for 4 ops -> grants 0,1,0,1; responses in same order.
REQ-033 op=11'b00000000011 -> err=1, out=0; rsp_ready low 5 cycles -> rsp_* stable, both readies low.
REQ-034 rst_n pulsed low in ISSUE -> all outputs at reset values, no rsp_valid after release until a new accept.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared op-code encodings and controller state type for the ALU request arbiter.
package alu_ctrl_pkg;

    localparam int OP_W = 11;

    localparam logic [OP_W-1:0] OP_ADD  = 11'b000_0000_0001;
    localparam logic [OP_W-1:0] OP_SUB  = 11'b000_0000_0010;
    localparam logic [OP_W-1:0] OP_MULT = 11'b000_0000_0100;
    localparam logic [OP_W-1:0] OP_DIV  = 11'b000_0000_1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/eight_bit_alu.sv
// Purely combinational 8-bit ALU; any op other than the four one-hot codes,
// or a divide by zero, flags an error and forces a zero result.
module eight_bit_alu
    import alu_ctrl_pkg::*;
(
    input  logic [7:0]      a,
    input  logic [7:0]      b,
    input  logic [OP_W-1:0] op,
    output logic [7:0]      out,
    output logic [2:0]      rem,
    output logic            err
);

    logic [7:0] b_safe;

    // Keeps the divider away from x-producing /0 in simulation; the result is masked anyway.
    assign b_safe = (b == 8'd0) ? 8'd1 : b;

    always_comb begin
        out = 8'd0;
        rem = 3'd0;
        err = 1'b0;
        case (op)
            OP_ADD:  out = a + b;
            OP_SUB:  out = (a >= b) ? (a - b) : (b - a);
            OP_MULT: out = a * b;
            OP_DIV: begin
                if (b == 8'd0) begin
                    err = 1'b1;
                end else begin
                    out = a / b_safe;
                    rem = 3'(a % b_safe);
                end
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared 8-bit ALU with a held response.
//
// state | meaning
// IDLE  | waiting for a command; the only state that asserts a ready
// ISSUE | latched operands driven into the ALU while it settles
// RESP  | result held on rsp_* until the consumer takes it
module alu_req_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [7:0]      req0_a,
    input  logic [7:0]      req0_b,
    input  logic [OP_W-1:0] req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [7:0]      req1_a,
    input  logic [7:0]      req1_b,
    input  logic [OP_W-1:0] req1_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [7:0]      rsp_out,
    output logic [2:0]      rsp_rem,
    output logic            rsp_err
);

    state_e          state_q, state_d;
    logic            prio_q, prio_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      a_q, b_q;
    logic [OP_W-1:0] op_q;
    logic            id_q;
    logic            rsp_valid_q;
    logic            rsp_id_q;
    logic [7:0]      rsp_out_q;
    logic [2:0]      rsp_rem_q;
    logic            rsp_err_q;

    logic            grant0, grant1;
    logic            accept;
    logic            capture;
    logic            taken;
    logic [7:0]      alu_out;
    logic [2:0]      alu_rem;
    logic            alu_err;

    // prio_q = 0 means requester 0 wins a tie.
    assign grant0 = req0_valid & (~req1_valid | ~prio_q);
    assign grant1 = req1_valid & (~req0_valid |  prio_q);

    assign req0_ready = (state_q == IDLE) & grant0;
    assign req1_ready = (state_q == IDLE) & grant1;
    assign accept     = req0_ready | req1_ready;

    assign capture = (state_q == ISSUE) && (cnt_q == 3'd0);
    assign taken   = (state_q == RESP) && rsp_ready;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    prio_d  = ~req1_ready;
                    cnt_d   = 3'(SETTLE_CYCLES);
                end
            end
            // First ISSUE cycle launches the operands; SETTLE_CYCLES more follow before capture.
            ISSUE: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= 8'd0;
            b_q  <= 8'd0;
            op_q <= '0;
            id_q <= 1'b0;
        end else if (accept) begin
            a_q  <= req1_ready ? req1_a  : req0_a;
            b_q  <= req1_ready ? req1_b  : req0_b;
            op_q <= req1_ready ? req1_op : req0_op;
            id_q <= req1_ready;
        end
    end

    eight_bit_alu u_alu (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .out (alu_out),
        .rem (alu_rem),
        .err (alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_out_q   <= 8'd0;
            rsp_rem_q   <= 3'd0;
            rsp_err_q   <= 1'b0;
        end else if (capture) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_out_q   <= alu_out;
            rsp_rem_q   <= alu_rem;
            rsp_err_q   <= alu_err;
        end else if (taken) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_rem   = rsp_rem_q;
    assign rsp_err   = rsp_err_q;

endmodule
